// File: rtl/fir_mac_sequencer.sv
// FIR multiply-accumulate sequencer.
// Drives the address and control lines for an external delay RAM, coefficient
// RAM and accumulator so that one N-tap convolution runs per accepted sample.
// Every output is a flop: the comb block computes the values for the next
// cycle and the register block loads them together with the state.
module fir_mac_sequencer #(
   parameter int N  = 255,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          sample_stb,
   input  logic          cfg_req,
   input  logic          ovr_clr,
   output logic          cfg_gnt,
   output logic          smp_we,
   output logic          smp_zero,
   output logic [AW-1:0] smp_addr,
   output logic [AW-1:0] coef_addr,
   output logic          mac_clr,
   output logic          mac_en,
   output logic          out_stb,
   output logic          busy,
   output logic          overrun
);

   typedef enum logic [2:0] {
      CLR   = 3'd0,
      IDLE  = 3'd1,
      WR    = 3'd2,
      MAC   = 3'd3,
      DRAIN = 3'd4,
      OUT   = 3'd5
   } StateType;

   // The counter needs one extra bit because CLR counts up to N, and N may be 2^AW.
   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
   localparam logic [AW-1:0] ONE_A    = AW'(1);
   localparam logic [AW:0]   N_CNT    = (AW+1)'(N);
   localparam logic [AW:0]   LAST_CNT = (AW+1)'(N - 1);
   localparam logic [AW:0]   ONE_C    = (AW+1)'(1);

   StateType      r_state;
   logic [AW:0]   r_cnt;
   logic [AW-1:0] r_wrPtr;
   logic          r_cfgGnt;
   logic          r_smpWe;
   logic          r_smpZero;
   logic [AW-1:0] r_smpAddr;
   logic [AW-1:0] r_coefAddr;
   logic          r_macClr;
   logic          r_macEn;
   logic          r_outStb;
   logic          r_busy;
   logic          r_overrun;

   StateType      w_stateNxt;
   logic [AW:0]   w_cntNxt;
   logic [AW-1:0] w_wrPtrNxt;
   logic          w_cfgGntNxt;
   logic          w_smpWeNxt;
   logic          w_smpZeroNxt;
   logic [AW-1:0] w_smpAddrNxt;
   logic [AW-1:0] w_coefAddrNxt;
   logic          w_macClrNxt;
   logic          w_macEnNxt;
   logic          w_outStbNxt;
   logic          w_busyNxt;
   logic          w_overrunNxt;
   logic          w_accept;
   logic          w_drop;

   // Next-state and next-output decode; every target gets its idle value first.
   always_comb begin
      w_accept      = (r_state == IDLE) && sample_stb && enable && !r_cfgGnt;
      w_drop        = sample_stb && enable && !w_accept;
      w_stateNxt    = r_state;
      w_cntNxt      = r_cnt;
      w_wrPtrNxt    = r_wrPtr;
      w_cfgGntNxt   = r_cfgGnt;
      w_smpWeNxt    = 1'b0;
      w_smpZeroNxt  = 1'b0;
      w_smpAddrNxt  = '0;
      w_coefAddrNxt = '0;
      w_macClrNxt   = 1'b0;
      w_macEnNxt    = 1'b0;
      w_outStbNxt   = 1'b0;
      // A drop in the same cycle as a clear request leaves the flag set.
      w_overrunNxt  = w_drop ? 1'b1 : (ovr_clr ? 1'b0 : r_overrun);

      unique case (r_state)
         CLR: begin
            // r_cnt counts zero-writes already issued; the reset cycle issues none.
            if (r_cnt == N_CNT) begin
               w_stateNxt = IDLE;
               w_cntNxt   = '0;
            end else begin
               w_smpWeNxt   = 1'b1;
               w_smpZeroNxt = 1'b1;
               w_smpAddrNxt = r_cnt[AW-1:0];
               w_cntNxt     = r_cnt + ONE_C;
            end
         end
         IDLE: begin
            // An accepted sample beats a coincident configuration request.
            if (w_accept) begin
               w_stateNxt   = WR;
               w_smpWeNxt   = 1'b1;
               w_smpAddrNxt = r_wrPtr;
               w_macClrNxt  = 1'b1;
            end else if (r_cfgGnt) begin
               if (!cfg_req) w_cfgGntNxt = 1'b0;
            end else if (cfg_req) begin
               w_cfgGntNxt = 1'b1;
            end
         end
         WR: begin
            w_stateNxt    = MAC;
            w_cntNxt      = '0;
            w_smpAddrNxt  = r_smpAddr;
            w_coefAddrNxt = '0;
         end
         MAC: begin
            // Read data of the previous tap arrives now, so accumulate it.
            w_macEnNxt = 1'b1;
            if (r_cnt == LAST_CNT) begin
               w_stateNxt = DRAIN;
               w_cntNxt   = '0;
            end else begin
               w_cntNxt      = r_cnt + ONE_C;
               w_smpAddrNxt  = (r_smpAddr == '0) ? LAST_IDX : (r_smpAddr - ONE_A);
               w_coefAddrNxt = r_cnt[AW-1:0] + ONE_A;
            end
         end
         DRAIN: begin
            w_stateNxt  = OUT;
            w_outStbNxt = 1'b1;
            w_wrPtrNxt  = (r_wrPtr == LAST_IDX) ? '0 : (r_wrPtr + ONE_A);
         end
         OUT: begin
            w_stateNxt = IDLE;
         end
         default: begin
            w_stateNxt = CLR;
            w_cntNxt   = '0;
         end
      endcase

      w_busyNxt = (w_stateNxt != IDLE);
   end

   // State, counters and all output flops; reset forces a fresh delay-RAM clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= CLR;
         r_cnt      <= '0;
         r_wrPtr    <= '0;
         r_cfgGnt   <= 1'b0;
         r_smpWe    <= 1'b0;
         r_smpZero  <= 1'b0;
         r_smpAddr  <= '0;
         r_coefAddr <= '0;
         r_macClr   <= 1'b0;
         r_macEn    <= 1'b0;
         r_outStb   <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_stateNxt;
         r_cnt      <= w_cntNxt;
         r_wrPtr    <= w_wrPtrNxt;
         r_cfgGnt   <= w_cfgGntNxt;
         r_smpWe    <= w_smpWeNxt;
         r_smpZero  <= w_smpZeroNxt;
         r_smpAddr  <= w_smpAddrNxt;
         r_coefAddr <= w_coefAddrNxt;
         r_macClr   <= w_macClrNxt;
         r_macEn    <= w_macEnNxt;
         r_outStb   <= w_outStbNxt;
         r_busy     <= w_busyNxt;
         r_overrun  <= w_overrunNxt;
      end
   end

   assign cfg_gnt   = r_cfgGnt;
   assign smp_we    = r_smpWe;
   assign smp_zero  = r_smpZero;
   assign smp_addr  = r_smpAddr;
   assign coef_addr = r_coefAddr;
   assign mac_clr   = r_macClr;
   assign mac_en    = r_macEn;
   assign out_stb   = r_outStb;
   assign busy      = r_busy;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: one N=4 instance for the main
// sequence, overrun, configuration and reset cases, and one N=5 instance for
// non-power-of-two wrap-around.
module tb_fir_mac_sequencer;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       sampleStb;
   logic       cfgReq;
   logic       ovrClr;
   logic       cfgGnt, smpWe, smpZero, macClr, macEn, outStb, busy, overrun;
   logic [7:0] smpAddr, coefAddr;

   logic       sampleStb5;
   logic       cfgReq5;
   logic       ovrClr5;
   logic       cfgGnt5, smpWe5, smpZero5, macClr5, macEn5, outStb5, busy5, overrun5;
   logic [7:0] smpAddr5, coefAddr5;

   int testCount = 0;
   int failCount = 0;

   fir_mac_sequencer #(.N(4), .AW(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sample_stb(sampleStb),
      .cfg_req(cfgReq), .ovr_clr(ovrClr), .cfg_gnt(cfgGnt), .smp_we(smpWe),
      .smp_zero(smpZero), .smp_addr(smpAddr), .coef_addr(coefAddr),
      .mac_clr(macClr), .mac_en(macEn), .out_stb(outStb), .busy(busy),
      .overrun(overrun)
   );

   fir_mac_sequencer #(.N(5), .AW(8)) dut5 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sample_stb(sampleStb5),
      .cfg_req(cfgReq5), .ovr_clr(ovrClr5), .cfg_gnt(cfgGnt5), .smp_we(smpWe5),
      .smp_zero(smpZero5), .smp_addr(smpAddr5), .coef_addr(coefAddr5),
      .mac_clr(macClr5), .mac_en(macEn5), .out_stb(outStb5), .busy(busy5),
      .overrun(overrun5)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge, where outputs are sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the N=4 instance's control inputs.
   task automatic applyStimulus(input logic stb, input logic en, input logic req, input logic clr);
      sampleStb = stb;
      enable    = en;
      cfgReq    = req;
      ovrClr    = clr;
   endtask

   // One comparison: count it, and report it if it differs.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Linear directed sequence.
   initial begin
      int mac4Rd[4];
      int mac5Rd[5];
      mac4Rd = '{0, 3, 2, 1};
      mac5Rd = '{0, 4, 3, 2, 1};

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      sampleStb5 = 1'b0;
      cfgReq5    = 1'b0;
      ovrClr5    = 1'b0;
      tick();
      tick();

      // Reset state
      checkOutput("rst_smp_we", {31'd0, smpWe}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
      checkOutput("rst_cfg_gnt", {31'd0, cfgGnt}, 32'd0);
      checkOutput("rst_smp_addr", {24'd0, smpAddr}, 32'd0);

      // CLR sweep after release
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput($sformatf("clr_we_%0d", i), {31'd0, smpWe}, 32'd1);
         checkOutput($sformatf("clr_zero_%0d", i), {31'd0, smpZero}, 32'd1);
         checkOutput($sformatf("clr_addr_%0d", i), {24'd0, smpAddr}, i);
         checkOutput($sformatf("clr_busy_%0d", i), {31'd0, busy}, 32'd1);
      end
      tick();
      checkOutput("clr_done_busy", {31'd0, busy}, 32'd0);
      checkOutput("clr_done_we", {31'd0, smpWe}, 32'd0);

      // First sample, wr_ptr=0
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("s1_wr_we", {31'd0, smpWe}, 32'd1);
      checkOutput("s1_wr_zero", {31'd0, smpZero}, 32'd0);
      checkOutput("s1_wr_addr", {24'd0, smpAddr}, 32'd0);
      checkOutput("s1_mac_clr", {31'd0, macClr}, 32'd1);
      checkOutput("s1_wr_mac_en", {31'd0, macEn}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput($sformatf("s1_rd_addr_%0d", k), {24'd0, smpAddr}, mac4Rd[k]);
         checkOutput($sformatf("s1_coef_%0d", k), {24'd0, coefAddr}, k);
         checkOutput($sformatf("s1_mac_en_%0d", k), {31'd0, macEn}, (k >= 1) ? 32'd1 : 32'd0);
         checkOutput($sformatf("s1_mac_clr_%0d", k), {31'd0, macClr}, 32'd0);
      end
      tick();
      checkOutput("s1_drain_mac_en", {31'd0, macEn}, 32'd1);
      checkOutput("s1_drain_out_stb", {31'd0, outStb}, 32'd0);
      checkOutput("s1_drain_addr", {24'd0, smpAddr}, 32'd0);
      tick();
      checkOutput("s1_out_stb", {31'd0, outStb}, 32'd1);
      checkOutput("s1_out_mac_en", {31'd0, macEn}, 32'd0);
      tick();
      checkOutput("s1_idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("s1_idle_out_stb", {31'd0, outStb}, 32'd0);
      checkOutput("s1_overrun", {31'd0, overrun}, 32'd0);

      // Second sample, wr_ptr=1, with overrun cases
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("s2_wr_addr", {24'd0, smpAddr}, 32'd1);
      tick();
      checkOutput("s2_rd0_addr", {24'd0, smpAddr}, 32'd1);
      tick();
      checkOutput("s2_rd1_addr", {24'd0, smpAddr}, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("s2_drop_overrun", {31'd0, overrun}, 32'd1);
      checkOutput("s2_rd2_addr", {24'd0, smpAddr}, 32'd3);
      checkOutput("s2_drop_no_we", {31'd0, smpWe}, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("s2_set_wins", {31'd0, overrun}, 32'd1);
      checkOutput("s2_rd3_addr", {24'd0, smpAddr}, 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("s2_ovr_clr", {31'd0, overrun}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("s2_out_stb_en_low", {31'd0, outStb}, 32'd1);
      checkOutput("s2_en_low_no_ovr", {31'd0, overrun}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("s2_idle_busy", {31'd0, busy}, 32'd0);

      // Third sample at minimum spacing, coincident with cfg_req
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("s3_sample_wins_we", {31'd0, smpWe}, 32'd1);
      checkOutput("s3_wr_addr", {24'd0, smpAddr}, 32'd2);
      checkOutput("s3_gnt_waits", {31'd0, cfgGnt}, 32'd0);
      for (int c = 2; c <= 7; c++) begin
         tick();
         checkOutput($sformatf("s3_gnt_busy_%0d", c), {31'd0, cfgGnt}, 32'd0);
         checkOutput($sformatf("s3_out_stb_%0d", c), {31'd0, outStb}, (c == 7) ? 32'd1 : 32'd0);
      end
      tick();
      checkOutput("s3_idle_gnt", {31'd0, cfgGnt}, 32'd0);
      checkOutput("s3_idle_busy", {31'd0, busy}, 32'd0);
      tick();
      checkOutput("cfg_gnt_rise", {31'd0, cfgGnt}, 32'd1);
      checkOutput("cfg_coef_zero", {24'd0, coefAddr}, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("cfg_drop_overrun", {31'd0, overrun}, 32'd1);
      checkOutput("cfg_drop_no_we", {31'd0, smpWe}, 32'd0);
      checkOutput("cfg_drop_no_busy", {31'd0, busy}, 32'd0);
      checkOutput("cfg_drop_no_mac_clr", {31'd0, macClr}, 32'd0);
      tick();
      checkOutput("cfg_ovr_clr", {31'd0, overrun}, 32'd0);
      checkOutput("cfg_gnt_held", {31'd0, cfgGnt}, 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("cfg_gnt_fall", {31'd0, cfgGnt}, 32'd0);

      // N=5: five samples at minimum spacing walk wr_ptr 0..4, then wrap
      for (int s = 0; s < 6; s++) begin
         sampleStb5 = 1'b1;
         tick();
         sampleStb5 = 1'b0;
         checkOutput($sformatf("n5_wr_we_%0d", s), {31'd0, smpWe5}, 32'd1);
         checkOutput($sformatf("n5_wr_addr_%0d", s), {24'd0, smpAddr5}, s % 5);
         for (int c = 2; c <= 9; c++) begin
            tick();
            if (s == 5 && c <= 6) begin
               checkOutput($sformatf("n5_rd_addr_%0d", c - 2), {24'd0, smpAddr5}, mac5Rd[c - 2]);
               checkOutput($sformatf("n5_coef_%0d", c - 2), {24'd0, coefAddr5}, c - 2);
            end
         end
         checkOutput($sformatf("n5_idle_%0d", s), {31'd0, busy5}, 32'd0);
      end
      checkOutput("n5_overrun", {31'd0, overrun5}, 32'd0);

      // Fourth N=4 sample, wr_ptr=3, aborted by reset at cycle 2
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("s4_wr_addr", {24'd0, smpAddr}, 32'd3);
      tick();
      checkOutput("s4_rd0_addr", {24'd0, smpAddr}, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_smp_addr", {24'd0, smpAddr}, 32'd0);
      checkOutput("arst_busy", {31'd0, busy}, 32'd0);
      checkOutput("arst_mac_en", {31'd0, macEn}, 32'd0);
      tick();
      checkOutput("arst_out_stb", {31'd0, outStb}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput($sformatf("reclr_addr_%0d", i), {24'd0, smpAddr}, i);
         checkOutput($sformatf("reclr_we_%0d", i), {31'd0, smpWe}, 32'd1);
         checkOutput($sformatf("reclr_no_out_%0d", i), {31'd0, outStb}, 32'd0);
      end
      tick();
      checkOutput("reclr_done_busy", {31'd0, busy}, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("s5_wr_ptr_reset", {24'd0, smpAddr}, 32'd0);
      checkOutput("s5_wr_we", {31'd0, smpWe}, 32'd1);
      for (int c = 2; c <= 8; c++) tick();
      checkOutput("s5_idle_busy", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
